// File: rtl/ecap5_dwbgpio_pkg.sv
// ecap5_dwbgpio shared definitions.
// Register map of the Wishbone GPIO slave.
package ecap5_dwbgpio_pkg;

    localparam int ADDR_W = 2;

    typedef enum logic [ADDR_W-1:0] {
        REG_OUT  = 2'd0,
        REG_IN   = 2'd1,
        REG_EDGE = 2'd2,
        REG_RSVD = 2'd3
    } reg_e;

endpackage

// File: rtl/ecap5_dwbgpio_debounce.sv
// ecap5_dwbgpio input conditioning.
// Two-flop synchroniser followed by a stability-window debouncer.
module ecap5_dwbgpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ;
    logic             settle;

    assign differ = sync_q[1] ^ level_q;
    assign settle = differ && (cnt_q == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            // counter clears on agreement or on settle, so it never wraps
            if (!differ || settle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (settle) begin
                level_q <= sync_q[1];
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = settle & sync_q[1];

endmodule

// File: rtl/ecap5_dwbgpio.sv
// ecap5_dwbgpio: Wishbone pipelined GPIO slave.
// OUT, debounced IN and sticky rising-edge EDGE registers.
module ecap5_dwbgpio
    import ecap5_dwbgpio_pkg::*;
#(
    parameter int NB_OUT          = 2,
    parameter int NB_IN           = 2,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    output logic [NB_OUT-1:0] gpio_o,
    input  logic [NB_IN-1:0]  gpio_i
);

    logic              req;
    logic              wr;
    reg_e              sel;
    logic [31:0]       rdata;
    logic [NB_IN-1:0]  clr;
    logic [NB_IN-1:0]  in_db;
    logic [NB_IN-1:0]  rise;
    logic [NB_OUT-1:0] out_q;
    logic [NB_IN-1:0]  edge_q;
    logic              ack_q;
    logic [31:0]       dat_q;
    logic              unused_bits;

    assign req = wb_cyc_i & wb_stb_i;
    assign wr  = req & wb_we_i & wb_sel_i[0];
    assign sel = reg_e'(wb_adr_i[3:2]);

    assign unused_bits = ^{wb_adr_i, wb_sel_i, wb_dat_i};

    for (genvar i = 0; i < NB_IN; i++) begin : g_in
        ecap5_dwbgpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .pin_i   (gpio_i[i]),
            .level_o (in_db[i]),
            .rise_o  (rise[i])
        );
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_OUT:  rdata[NB_OUT-1:0] = out_q;
            REG_IN:   rdata[NB_IN-1:0]  = in_db;
            REG_EDGE: rdata[NB_IN-1:0]  = edge_q;
            default:  rdata = '0;
        endcase
    end

    always_comb begin
        clr = '0;
        if (wr && sel == REG_EDGE) begin
            clr = wb_dat_i[NB_IN-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            out_q  <= '0;
            edge_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= req ? rdata : '0;
            if (wr && sel == REG_OUT) begin
                out_q <= wb_dat_i[NB_OUT-1:0];
            end
            // a new edge wins over a same-cycle clear
            edge_q <= (edge_q & ~clr) | rise;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = out_q;

endmodule

// File: tb/tb_ecap5_dwbgpio.sv
// Scoreboard bench for ecap5_dwbgpio.
// Reference model tracks inputs as sample history and run lengths.
module tb_ecap5_dwbgpio;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic [1:0]  gpio_o;
    logic [1:0]  gpio_i = '0;

    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] dat;
        bit          chk;
        logic [31:0] adr;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] m_out = '0;
    logic [1:0] m_in = '0;
    logic [1:0] m_edge = '0;
    int         m_run[2] = '{0, 0};
    logic [1:0] hist[$];

    ecap5_dwbgpio #(
        .NB_OUT(2),
        .NB_IN(2),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_stb_i   (wb_stb),
        .wb_cyc_i   (wb_cyc),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .gpio_o     (gpio_o),
        .gpio_i     (gpio_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, got, want, $time);
        end
    endtask

    // reference model reset: everything clears, pending acks are lost
    always @(negedge rst_n) begin
        exp_q.delete();
        hist.delete();
        m_out = '0;
        m_in = '0;
        m_edge = '0;
        m_run[0] = 0;
        m_run[1] = 0;
    end

    // reference model step on each rising edge
    always @(posedge clk) begin : model
        logic [1:0]  s;
        logic [1:0]  rise;
        logic [1:0]  clr;
        logic [31:0] rd;
        logic [1:0]  reg_idx;
        if (rst_n) begin
            rise = '0;
            clr = '0;
            reg_idx = wb_adr[3:2];
            if (wb_cyc && wb_stb) begin
                rd = '0;
                case (reg_idx)
                    2'd0: rd = {30'd0, m_out};
                    2'd1: rd = {30'd0, m_in};
                    2'd2: rd = {30'd0, m_edge};
                    default: rd = '0;
                endcase
                exp_q.push_back('{dat: rd, chk: !wb_we, adr: wb_adr});
            end
            // input as seen after two sampling edges
            s = (hist.size() == 2) ? hist[0] : 2'b00;
            hist.push_back(gpio_i);
            if (hist.size() > 2) void'(hist.pop_front());
            for (int i = 0; i < 2; i++) begin
                if (s[i] != m_in[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_in[i] = s[i];
                        m_run[i] = 0;
                        rise[i] = s[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (wb_cyc && wb_stb && wb_we && wb_sel[0]) begin
                if (reg_idx == 2'd0) m_out = wb_dat[1:0];
                if (reg_idx == 2'd2) clr = wb_dat[1:0];
            end
            m_edge = (m_edge & ~clr) | rise;
        end
    end

    // monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   want;
        want = exp_q.size() != 0;
        check("ack", {31'd0, wb_ack_o}, {31'd0, want});
        if (want) begin
            e = exp_q.pop_front();
            if (wb_ack_o && e.chk) begin
                check($sformatf("rdata@%h", e.adr), wb_dat_o, e.dat);
            end
        end
        if (!wb_ack_o) begin
            check("dat_idle", wb_dat_o, 32'd0);
        end
        check("stall", {31'd0, wb_stall_o}, 32'd0);
        check("gpio_o", {30'd0, gpio_o}, {30'd0, m_out});
    end

    task automatic req(input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
        wb_adr = adr;
        wb_dat = dat;
        wb_sel = sel;
        wb_we = we;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_gpio", {30'd0, gpio_o}, 32'd0);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // OUT write then read
        req(32'h0000_0000, 32'h3, 4'h1, 1'b1);
        #1 check("out_write_gpio", {30'd0, gpio_o}, 32'h3);
        req(32'h0000_0000, 32'h0, 4'h0, 1'b0);
        idle(1);

        // write masked by sel[0]=0
        req(32'h0000_0000, 32'h0, 4'h2, 1'b1);
        idle(1);
        #1 check("sel_mask_gpio", {30'd0, gpio_o}, 32'h3);

        // short glitch on gpio_i[0]
        gpio_i[0] = 1'b1;
        idle(3);
        gpio_i[0] = 1'b0;
        idle(10);
        req(32'h0000_0004, 32'h0, 4'hf, 1'b0);
        req(32'h0000_0008, 32'h0, 4'hf, 1'b0);
        idle(2);

        // stable press on gpio_i[1], IN polled every cycle
        gpio_i[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req(32'h0000_0004, 32'h0, 4'hf, 1'b0);
        end
        req(32'h0000_0008, 32'h0, 4'hf, 1'b0);
        req(32'h0000_0008, 32'h2, 4'h1, 1'b1);
        req(32'h0000_0008, 32'h0, 4'hf, 1'b0);
        idle(1);

        // back-to-back reads, with junk in ignored address bits
        req(32'hABCD_0003, 32'h0, 4'hf, 1'b0);
        req(32'h1234_5006, 32'h0, 4'hf, 1'b0);
        req(32'hFFFF_FFFC, 32'h0, 4'hf, 1'b0);
        req(32'h0000_0004, 32'hFFFF_FFFF, 4'h1, 1'b1);
        idle(2);

        // reset during the ack cycle of a write
        wb_adr = 32'h0;
        wb_dat = 32'h1;
        wb_sel = 4'h1;
        wb_we = 1'b1;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        @(posedge clk);
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_mid_gpio", {30'd0, gpio_o}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        req(32'h0000_0000, 32'h0, 4'hf, 1'b0);
        idle(1);

        // randomized traffic and input activity
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                gpio_i = gpio_i ^ 2'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) != 0) begin
                wb_adr = $urandom;
                wb_dat = $urandom;
                wb_sel = 4'($urandom);
                wb_we = 1'($urandom);
                wb_cyc = 1'b1;
                wb_stb = ($urandom_range(0, 7) != 0);
            end else begin
                wb_cyc = 1'b0;
                wb_stb = 1'($urandom);
                wb_we = 1'($urandom);
            end
            @(negedge clk);
        end
        idle(12);
        req(32'h0000_0004, 32'h0, 4'hf, 1'b0);
        req(32'h0000_0008, 32'h0, 4'hf, 1'b0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ecap5_dwbgpio.md
ECAP5_DWBGPIO -- requirements
Module: ecap5_dwbgpio

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NB_OUT, default 2, SHALL set the number of output pins (1..8).
REQ-003 Parameter NB_IN, default 2, SHALL set the number of input pins (1..8).
REQ-004 Parameter DEBOUNCE_CYCLES, default 240000 (10 ms at 24 MHz), SHALL set the input stability window (>=2).
REQ-005 Port clk_i  in  1  system clock; all state is on its rising edge.
REQ-006 Port rst_n_i  in  1  asynchronous active-low reset.
REQ-007 Ports wb_adr_i in 32, wb_dat_i in 32, wb_sel_i in 4, wb_we_i in 1, wb_stb_i in 1, wb_cyc_i in 1 SHALL form the Wishbone pipelined slave request.
REQ-008 Ports wb_dat_o out 32, wb_ack_o out 1, wb_stall_o out 1 SHALL form the Wishbone slave response.
REQ-009 Port gpio_o  out  NB_OUT  output pins (LEDs).
REQ-010 Port gpio_i  in  NB_IN  asynchronous input pins (buttons).

Function
REQ-011 A request SHALL be accepted in any cycle with wb_cyc_i=1 and wb_stb_i=1; wb_stall_o SHALL be constant 0.
REQ-012 wb_ack_o SHALL be asserted exactly one cycle after each accepted request, for one cycle, with wb_dat_o valid in that cycle; back-to-back requests SHALL yield back-to-back acks.
REQ-013 wb_dat_o SHALL be 0 in every cycle wb_ack_o=0.
REQ-014 The register SHALL be selected by wb_adr_i[3:2]; wb_adr_i[31:4] and [1:0] SHALL be ignored.
REQ-015 Offset 0x0 OUT: read/write, bits [NB_OUT-1:0] drive gpio_o directly from the register.
REQ-016 Offset 0x4 IN: read-only, bits [NB_IN-1:0] return debounced input levels; writes ignored.
REQ-017 Offset 0x8 EDGE: bits [NB_IN-1:0] are sticky rising-edge flags of the debounced inputs; writing 1 to a bit clears it, writing 0 has no effect.
REQ-018 Offset 0xC SHALL read 0, ignore writes, and still be acknowledged.
REQ-019 Writes SHALL take effect only when wb_sel_i[0]=1; wb_sel_i[3:1] SHALL be ignored.
REQ-020 Unimplemented register bits SHALL read 0.
REQ-021 Each gpio_i bit SHALL pass through a 2-flop synchroniser before debouncing.
REQ-022 Debounce: a per-bit counter SHALL reset to 0 whenever synchronised value equals debounced value, otherwise increment; when it reaches DEBOUNCE_CYCLES-1 the debounced value SHALL take the synchronised value and the counter SHALL reset.
REQ-023 An input pulse shorter than DEBOUNCE_CYCLES consecutive cycles SHALL never change the debounced value.
REQ-024 The counter width SHALL be $clog2(DEBOUNCE_CYCLES) and SHALL never wrap.
REQ-025 A debounced 0->1 transition SHALL set its EDGE bit in the same cycle the IN bit changes; set and write-1-clear in the same cycle SHALL leave the bit set.
REQ-026 A read of EDGE SHALL return the value before any clear in that cycle.

Reset
REQ-027 While rst_n_i=0: gpio_o=0, wb_ack_o=0, wb_dat_o=0, OUT=0, EDGE=0, synchronisers, debounced values and counters =0.
REQ-028 Reset asserted mid-transaction SHALL drop any pending ack; the first request after release SHALL be served normally.

Structure
REQ-029 Package ecap5_dwbgpio_pkg SHALL hold register offset constants (OUT, IN, EDGE) and the address-field width.
REQ-030 Synchroniser plus debounce SHALL be one sub-module, ecap5_dwbgpio_debounce, instantiated per input bit.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 Write 0x3 to 0x0, sel=0x1 -> ack next cycle, gpio_o=2'b11 in that cycle; read 0x0 -> 0x00000003.
REQ-032 Write 0x0 to 0x0 with sel=0x2 -> gpio_o unchanged at 2'b11.
REQ-033 gpio_i[0] high 3 cycles then low -> IN reads 0, EDGE reads 0.
REQ-034 gpio_i[1] held high -> IN[1]=1 exactly 2+4 cycles after the change, EDGE=0x2; write 0x2 to 0x8 -> EDGE reads 0.
REQ-035 Three back-to-back reads of 0x0, 0x4, 0xC -> three consecutive acks carrying OUT, IN, 0.
REQ-036 rst_n_i pulsed low during ack cycle of a write -> ack and gpio_o 0 immediately; next read of 0x0 returns 0.
